// File: rtl/seq_alu.sv
// seq_alu: handshaked RV32I/RV32M integer execution unit.
// Base ALU ops finish in one cycle; MUL*/DIV*/REM* iterate one bit per cycle.
// The result register is loaded only when the FSM enters DONE and holds there
// until the consumer takes it.

module seq_alu #(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [4:0]      op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic            zero,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int              CNTW = SHW + 1;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    // FSM and result registers
    state_t            r_state;
    logic [XLEN-1:0]   r_out;
    logic              r_zero;
    logic [CNTW-1:0]   r_cnt;

    // Multiplier datapath: accumulator, left-shifting multiplicand, right-shifting multiplier
    logic [2*XLEN-1:0] r_acc;
    logic [2*XLEN-1:0] r_mcand;
    logic [XLEN-1:0]   r_mplier;

    // Divider datapath: dividend bits shift out of r_quot as quotient bits shift in
    logic [XLEN-1:0]   r_quot;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_dvs;

    // Final-fixup controls captured at accept
    logic              r_neg_q;   // negate product / quotient
    logic              r_neg_r;   // negate remainder (dividend was negative)
    logic              r_sel;     // MUL: take high half; DIV: return remainder

    logic              w_accept;
    logic [SHW-1:0]    w_shamt;
    logic [XLEN-1:0]   w_base_res;
    logic              w_sa;
    logic              w_sb;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_is_div;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic [XLEN-1:0]   w_quick_res;
    logic              w_quick;
    logic              w_last;
    logic [2*XLEN-1:0] w_acc_nxt;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res;
    logic [XLEN:0]     w_trial;
    logic              w_fits;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [XLEN-1:0]   w_quot_nxt;
    logic [XLEN-1:0]   w_div_res;

    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_MUL) || (r_state == S_DIV);
    assign out       = r_out;
    assign zero      = r_zero;
    assign w_accept  = in_valid && in_ready;
    assign w_shamt   = in2[SHW-1:0];
    assign w_last    = (r_cnt == CNTW'(XLEN - 1));

    // Single-cycle base ALU result from the live request operands
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_base_res = '0;
        case (op[3:0])
            4'b0000: w_base_res = in1 & in2;
            4'b0001: w_base_res = in1 | in2;
            4'b0010: w_base_res = in1 + in2;
            4'b0110: w_base_res = in1 - in2;
            4'b0101: w_base_res = in1 ^ in2;
            4'b1000: w_base_res = in1 >> w_shamt;
            4'b1001: w_base_res = $signed(in1) >>> w_shamt;
            4'b1010: w_base_res = in1 << w_shamt;
            4'b1100: w_base_res = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
            4'b1101: w_base_res = {{(XLEN-1){1'b0}}, (in1 < in2)};
            default: w_base_res = '0;
        endcase
    end

    // Operand signedness, magnitudes and the divide special cases that skip iteration
    always_comb begin
        w_is_div    = op[4] && op[2];
        // Multiply: MUL/MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned.
        // Divide: even low bit (DIV/REM) is signed.
        w_sa        = op[2] ? ~op[0] : (op[1:0] != 2'b11);
        w_sb        = op[2] ? ~op[0] : ~op[1];
        w_a_neg     = w_sa && in1[XLEN-1];
        w_b_neg     = w_sb && in2[XLEN-1];
        w_a_mag     = w_a_neg ? (~in1 + 1'b1) : in1;
        w_b_mag     = w_b_neg ? (~in2 + 1'b1) : in2;
        w_div_zero  = w_is_div && (in2 == '0);
        w_div_ovf   = w_is_div && ~op[0] && (in1 == SMIN) && (in2 == '1);
        w_quick     = !op[4] || w_div_zero || w_div_ovf;
        w_quick_res = w_base_res;
        if (w_div_zero) begin
            w_quick_res = op[1] ? in1 : '1;
        end else if (w_div_ovf) begin
            w_quick_res = op[1] ? '0 : SMIN;
        end
    end

    // One iteration step of each engine plus the sign fixup applied on the final step
    always_comb begin
        w_acc_nxt  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        w_prod     = r_neg_q ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
        w_mul_res  = r_sel ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];

        w_trial    = {r_rem, r_quot[XLEN-1]} - {1'b0, r_dvs};
        w_fits     = ~w_trial[XLEN];
        w_rem_nxt  = w_fits ? w_trial[XLEN-1:0] : {r_rem[XLEN-2:0], r_quot[XLEN-1]};
        w_quot_nxt = {r_quot[XLEN-2:0], w_fits};
        if (r_sel) begin
            w_div_res = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
        end else begin
            w_div_res = r_neg_q ? (~w_quot_nxt + 1'b1) : w_quot_nxt;
        end
    end

    // Control FSM with datapath registers; result written only on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_out    <= '0;
            r_zero   <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_sel    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            case (r_state)
                S_MUL: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNTW'(1);
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                        r_out   <= w_mul_res;
                        r_zero  <= (w_mul_res == '0);
                    end
                end
                S_DIV: begin
                    r_rem  <= w_rem_nxt;
                    r_quot <= w_quot_nxt;
                    r_cnt  <= r_cnt + CNTW'(1);
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                        r_out   <= w_div_res;
                        r_zero  <= (w_div_res == '0);
                    end
                end
                default: begin
                    // IDLE, or DONE while the consumer may be taking the result
                    if (w_accept) begin
                        r_cnt <= '0;
                        if (w_quick) begin
                            r_state <= S_DONE;
                            r_out   <= w_quick_res;
                            r_zero  <= (w_quick_res == '0);
                        end else if (op[2]) begin
                            r_state <= S_DIV;
                            r_quot  <= w_a_mag;
                            r_rem   <= '0;
                            r_dvs   <= w_b_mag;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                            r_sel   <= op[1];
                        end else begin
                            r_state  <= S_MUL;
                            r_acc    <= '0;
                            r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
                            r_mplier <= w_b_mag;
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= 1'b0;
                            r_sel    <= (op[1:0] != 2'b00);
                        end
                    end else if ((r_state == S_DONE) && out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu (XLEN = 32).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_seq_alu;

    localparam logic [4:0] OP_AND    = 5'b00000;
    localparam logic [4:0] OP_OR     = 5'b00001;
    localparam logic [4:0] OP_ADD    = 5'b00010;
    localparam logic [4:0] OP_XOR    = 5'b00101;
    localparam logic [4:0] OP_SUB    = 5'b00110;
    localparam logic [4:0] OP_SRL    = 5'b01000;
    localparam logic [4:0] OP_SRA    = 5'b01001;
    localparam logic [4:0] OP_SLL    = 5'b01010;
    localparam logic [4:0] OP_SLT    = 5'b01100;
    localparam logic [4:0] OP_SLTU   = 5'b01101;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        zero;
    logic        busy;

    int total = 0;
    int bad   = 0;

    seq_alu #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request at a falling edge, scramble the inputs after accept and
    // wait (bounded) for the result. lat counts cycles from accept to out_valid.
    task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic z, output int lat,
                          output int nbusy);
        op       = o;
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op       = ~o;
        in1      = ~a;
        in2      = ~b;
        lat      = 1;
        nbusy    = 0;
        while (!out_valid && lat < 100) begin
            if (busy) nbusy++;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        res = out;
        z   = zero;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = '0;
        in1       = '0;
        in2       = '0;
        repeat (2) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got=%b want=0", out_valid); bad++; end
        total++; if (busy !== 1'b0) begin $display("FAIL reset_busy got=%b want=0", busy); bad++; end
        total++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready got=%b want=1", in_ready); bad++; end
        total++; if (out !== 32'h0) begin $display("FAIL reset_out got=%h want=00000000", out); bad++; end
        total++; if (zero !== 1'b1) begin $display("FAIL reset_zero got=%b want=1", zero); bad++; end
        rst_n = 1'b1;
    endtask

    task automatic test_base();
        vec_t v[$];
        logic [31:0] res;
        logic        z;
        int          lat;
        int          nb;
        v.push_back('{"add_ovf",  OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1});
        v.push_back('{"sub_zero", OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1});
        v.push_back('{"sub_neg",  OP_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1});
        v.push_back('{"sra",      OP_SRA,  32'h80000000, 32'h00000021, 32'hC0000000, 1});
        v.push_back('{"srl",      OP_SRL,  32'h80000000, 32'h0000001F, 32'h00000001, 1});
        v.push_back('{"sll",      OP_SLL,  32'h00000001, 32'h0000001F, 32'h80000000, 1});
        v.push_back('{"slt",      OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1});
        v.push_back('{"sltu",     OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
        v.push_back('{"slt_rev",  OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1});
        v.push_back('{"sltu_rev", OP_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1});
        v.push_back('{"and",      OP_AND,  32'hF0F0F0F0, 32'h3C3C3C3C, 32'h30303030, 1});
        v.push_back('{"or",       OP_OR,   32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1});
        v.push_back('{"xor",      OP_XOR,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1});
        v.push_back('{"op07",     5'h07,   32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1});
        v.push_back('{"op0f",     5'h0F,   32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1});
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, res, z, lat, nb);
            total++; if (res !== v[i].exp) begin $display("FAIL %s result got=%h want=%h", v[i].name, res, v[i].exp); bad++; end
            total++; if (z !== (v[i].exp == 32'h0)) begin $display("FAIL %s zero got=%b want=%b", v[i].name, z, (v[i].exp == 32'h0)); bad++; end
            total++; if (lat !== v[i].lat) begin $display("FAIL %s latency got=%0d want=%0d", v[i].name, lat, v[i].lat); bad++; end
        end
    endtask

    task automatic test_mul();
        vec_t v[$];
        logic [31:0] res;
        logic        z;
        int          lat;
        int          nb;
        v.push_back('{"mul_m1m1",    OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33});
        v.push_back('{"mulh_m1m1",   OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33});
        v.push_back('{"mulhu_m1m1",  OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
        v.push_back('{"mulhsu_m1m1", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33});
        v.push_back('{"mul_x9",      OP_MUL,    32'h12345678, 32'h00000009, 32'hA3D70A38, 33});
        v.push_back('{"mul_neg",     OP_MUL,    32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 33});
        v.push_back('{"mulh_min2",   OP_MULH,   32'h80000000, 32'h00000002, 32'hFFFFFFFF, 33});
        v.push_back('{"mulhu_min2",  OP_MULHU,  32'h80000000, 32'h00000002, 32'h00000001, 33});
        v.push_back('{"mulhsu_min",  OP_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33});
        v.push_back('{"mul_zero",    OP_MUL,    32'h00000000, 32'h00000005, 32'h00000000, 33});
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, res, z, lat, nb);
            total++; if (res !== v[i].exp) begin $display("FAIL %s result got=%h want=%h", v[i].name, res, v[i].exp); bad++; end
            total++; if (z !== (v[i].exp == 32'h0)) begin $display("FAIL %s zero got=%b want=%b", v[i].name, z, (v[i].exp == 32'h0)); bad++; end
            total++; if (lat !== v[i].lat) begin $display("FAIL %s latency got=%0d want=%0d", v[i].name, lat, v[i].lat); bad++; end
            total++; if (nb !== 32) begin $display("FAIL %s busy_cycles got=%0d want=32", v[i].name, nb); bad++; end
        end
    endtask

    task automatic test_div();
        vec_t v[$];
        logic [31:0] res;
        logic        z;
        int          lat;
        int          nb;
        v.push_back('{"div_neg7_2",   OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33});
        v.push_back('{"rem_neg7_2",   OP_REM,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33});
        v.push_back('{"divu_by0",     OP_DIVU, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 1});
        v.push_back('{"remu_by0",     OP_REMU, 32'h00000007, 32'h00000000, 32'h00000007, 1});
        v.push_back('{"div_by0",      OP_DIV,  32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1});
        v.push_back('{"rem_by0",      OP_REM,  32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1});
        v.push_back('{"div_ovf",      OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        v.push_back('{"rem_ovf",      OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
        v.push_back('{"divu_100_7",   OP_DIVU, 32'h00000064, 32'h00000007, 32'h0000000E, 33});
        v.push_back('{"remu_100_7",   OP_REMU, 32'h00000064, 32'h00000007, 32'h00000002, 33});
        v.push_back('{"div_7_neg2",   OP_DIV,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33});
        v.push_back('{"rem_7_neg2",   OP_REM,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33});
        v.push_back('{"div_min_3",    OP_DIV,  32'h80000000, 32'h00000003, 32'hD5555556, 33});
        v.push_back('{"rem_min_3",    OP_REM,  32'h80000000, 32'h00000003, 32'hFFFFFFFE, 33});
        v.push_back('{"divu_min_m1",  OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33});
        v.push_back('{"remu_min_m1",  OP_REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33});
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, res, z, lat, nb);
            total++; if (res !== v[i].exp) begin $display("FAIL %s result got=%h want=%h", v[i].name, res, v[i].exp); bad++; end
            total++; if (z !== (v[i].exp == 32'h0)) begin $display("FAIL %s zero got=%b want=%b", v[i].name, z, (v[i].exp == 32'h0)); bad++; end
            total++; if (lat !== v[i].lat) begin $display("FAIL %s latency got=%0d want=%0d", v[i].name, lat, v[i].lat); bad++; end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            total++; if (in_ready !== 1'b1) begin $display("FAIL b2b_in_ready[%0d] got=%b want=1", i, in_ready); bad++; end
            op       = OP_ADD;
            in1      = 32'(i * 16);
            in2      = 32'h1;
            in_valid = 1'b1;
            exp      = 32'(i * 16 + 1);
            @(posedge clk);
            @(negedge clk);
            total++; if (out_valid !== 1'b1) begin $display("FAIL b2b_valid[%0d] got=%b want=1", i, out_valid); bad++; end
            total++; if (out !== exp) begin $display("FAIL b2b_out[%0d] got=%h want=%h", i, out, exp); bad++; end
        end
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin $display("FAIL b2b_drain got=%b want=0", out_valid); bad++; end
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        logic        z;
        int          lat;
        int          nb;
        out_ready = 1'b0;
        run_op(OP_MUL, 32'h3, 32'h5, res, z, lat, nb);
        total++; if (res !== 32'h0000000F) begin $display("FAIL bp_mul got=%h want=0000000f", res); bad++; end
        total++; if (lat !== 33) begin $display("FAIL bp_mul_latency got=%0d want=33", lat); bad++; end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            total++; if (out !== 32'h0000000F) begin $display("FAIL bp_hold_out[%0d] got=%h want=0000000f", i, out); bad++; end
            total++; if (out_valid !== 1'b1) begin $display("FAIL bp_hold_valid[%0d] got=%b want=1", i, out_valid); bad++; end
            total++; if (in_ready !== 1'b0) begin $display("FAIL bp_hold_in_ready[%0d] got=%b want=0", i, in_ready); bad++; end
        end
        out_ready = 1'b1;
        op        = OP_ADD;
        in1       = 32'h10;
        in2       = 32'h20;
        in_valid  = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin $display("FAIL bp_release_in_ready got=%b want=1", in_ready); bad++; end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin $display("FAIL bp_add_valid got=%b want=1", out_valid); bad++; end
        total++; if (out !== 32'h00000030) begin $display("FAIL bp_add_out got=%h want=00000030", out); bad++; end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin $display("FAIL bp_add_consumed got=%b want=0", out_valid); bad++; end
    endtask

    task automatic test_reset_mid_div();
        logic [31:0] res;
        logic        z;
        int          lat;
        int          nb;
        int          seen;
        out_ready = 1'b1;
        op        = OP_DIVU;
        in1       = 32'h00000064;
        in2       = 32'h00000007;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        total++; if (busy !== 1'b1) begin $display("FAIL rst_mid_busy_before got=%b want=1", busy); bad++; end
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin $display("FAIL rst_mid_out_valid got=%b want=0", out_valid); bad++; end
        total++; if (busy !== 1'b0) begin $display("FAIL rst_mid_busy got=%b want=0", busy); bad++; end
        total++; if (in_ready !== 1'b1) begin $display("FAIL rst_mid_in_ready got=%b want=1", in_ready); bad++; end
        total++; if (out !== 32'h0) begin $display("FAIL rst_mid_out got=%h want=00000000", out); bad++; end
        total++; if (zero !== 1'b1) begin $display("FAIL rst_mid_zero got=%b want=1", zero); bad++; end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_ADD, 32'h2, 32'h3, res, z, lat, nb);
        total++; if (res !== 32'h00000005) begin $display("FAIL rst_after_add got=%h want=00000005", res); bad++; end
        total++; if (lat !== 1) begin $display("FAIL rst_after_add_latency got=%0d want=1", lat); bad++; end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        total++; if (seen !== 0) begin $display("FAIL rst_no_stale_result got=%0d want=0", seen); bad++; end
    endtask

    initial begin
        test_reset();
        test_base();
        test_mul();
        test_div();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

endmodule
